// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
//   Sums NUM_TERMS signed products from the Booth multiplier into a wider
//   signed accumulator and hands the finished sum downstream.
//
//   Optional feature macro: ACC_SATURATE_EN
//     defined   : on signed overflow the sum clamps to the most positive or
//                 most negative ACC_W value
//     undefined : the sum wraps modulo 2^ACC_W
//     The overflow flag is set in both builds.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   clear        synchronous abort of the sum in progress
//   prod_valid / prod_ready / prod_data   product input stream
//   acc_valid  / acc_ready  / acc_data    result output stream
//   overflow     sticky signed-overflow flag for the current sum
//   term_count   products accepted into the current sum
module booth_product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int NUM_TERMS = 4,
    parameter int CNT_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [PROD_W-1:0] prod_data,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic signed [ACC_W-1:0]  acc_data,
    output logic                     overflow,
    output logic [CNT_W-1:0]         term_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // term_count value while the last term of a sum is being accepted
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

`ifdef ACC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic [1:0]               state, state_nxt;
    logic signed [ACC_W-1:0]  prod_ext, sum_raw, sum_fix, acc_nxt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic                     ovf_nxt, add_ovf, accept;

    // signed cast sign-extends the product to the accumulator width
    assign prod_ext = ACC_W'(prod_data);
    assign sum_raw  = acc_data + prod_ext;

    // overflow: both operands share a sign and the sum's sign differs
    assign add_ovf = (acc_data[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_raw[ACC_W-1]  != acc_data[ACC_W-1]);

`ifdef ACC_SATURATE_EN
    // the accumulator's sign tells which rail was crossed
    assign sum_fix = add_ovf ? (acc_data[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
    assign sum_fix = sum_raw;
`endif

    // prod_ready is a registered copy of "not in HOLD"; clear blocks the
    // accept even though prod_ready still reads 1 that cycle
    assign accept = prod_valid & prod_ready & ~clear;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_data;
        cnt_nxt   = term_count;
        ovf_nxt   = overflow;
        if (clear) begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc_nxt   = prod_ext;
                        cnt_nxt   = CNT_W'(1);
                        ovf_nxt   = 1'b0;
                        state_nxt = (NUM_TERMS == 1) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_nxt = sum_fix;
                        cnt_nxt = term_count + CNT_W'(1);
                        ovf_nxt = overflow | add_ovf;
                        if (term_count == LAST_CNT)
                            state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (acc_ready) begin
                        state_nxt = ST_IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

    // handshake outputs are registered from the next state so they are
    // glitch-free and prod_ready stays low while reset is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc_data   <= '0;
            term_count <= '0;
            overflow   <= 1'b0;
            prod_ready <= 1'b0;
            acc_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc_data   <= acc_nxt;
            term_count <= cnt_nxt;
            overflow   <= ovf_nxt;
            prod_ready <= (state_nxt != ST_HOLD);
            acc_valid  <= (state_nxt == ST_HOLD);
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Scoreboard bench for booth_product_accumulator.
//   u_dut : ACC_W=8, NUM_TERMS=4 (narrow accumulator so overflow is reachable)
//   u_one : ACC_W=16, NUM_TERMS=1 (single-term sums, sign extension)
// Expected sums come from integer arithmetic on the accepted products.
module tb_booth_product_accumulator;

    localparam int AW = 8;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic              clear = 1'b0, prod_valid = 1'b0, acc_ready = 1'b0;
    logic              prod_ready, acc_valid, overflow;
    logic signed [7:0] prod_data = '0;
    logic signed [AW-1:0] acc_data;
    logic [2:0]        term_count;

    // single-term instance
    logic               c_clear = 1'b0, c_valid = 1'b0, c_acc_ready = 1'b1;
    logic               c_ready, c_acc_valid, c_ovf;
    logic signed [7:0]  c_data = '0;
    logic signed [15:0] c_acc;
    logic [0:0]         c_cnt;

    booth_product_accumulator #(.PROD_W(8), .ACC_W(AW), .NUM_TERMS(NT), .CNT_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .overflow(overflow), .term_count(term_count)
    );

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .NUM_TERMS(1), .CNT_W(1)) u_one (
        .clk(clk), .rst_n(rst_n), .clear(c_clear),
        .prod_valid(c_valid), .prod_ready(c_ready), .prod_data(c_data),
        .acc_valid(c_acc_valid), .acc_ready(c_acc_ready), .acc_data(c_acc),
        .overflow(c_ovf), .term_count(c_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { int acc; bit ovf; int cnt; } exp_t;
    exp_t exp_q[$];

    // reference model state for the sum in progress
    int m_acc = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_accept(input int p);
        int s;
        int lo = -(1 << (AW-1));
        int hi = (1 << (AW-1)) - 1;
        exp_t e;
        if (m_cnt == 0) begin
            m_acc = p;
            m_ovf = 1'b0;
        end else begin
            s = m_acc + p;
            if (s > hi || s < lo) begin
                m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
                s = (s > hi) ? hi : lo;
`else
                s = (s > hi) ? s - (1 << AW) : s + (1 << AW);
`endif
            end
            m_acc = s;
        end
        m_cnt++;
        if (m_cnt == NT) begin
            e.acc = m_acc; e.ovf = m_ovf; e.cnt = NT;
            exp_q.push_back(e);
            m_cnt = 0;
        end
    endfunction

    // present one product, wait for its accept, check running state, then idle `gap` cycles
    task automatic send(input int p, input int gap);
        int  t;
        bit  rdy;
        bit  done;
        t = 0;
        prod_valid = 1'b1;
        prod_data  = 8'(p);
        forever begin
            rdy = prod_ready;
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
            t++;
            if (t > 200) begin
                chk("send_timeout", 1, 0);
                prod_valid = 1'b0;
                return;
            end
        end
        model_accept(p);
        @(negedge clk);
        prod_valid = 1'b0;
        done = (m_cnt == 0);
        chk("run_term_count", int'(term_count), done ? NT : m_cnt);
        chk("run_acc_data", int'(acc_data), m_acc);
        chk("run_acc_valid", int'(acc_valid), int'(done));
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_clear(input int p);
        prod_valid = 1'b1;
        prod_data  = 8'(p);
        clear      = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        prod_valid = 1'b0;
        m_cnt = 0; m_acc = 0; m_ovf = 1'b0;
        chk("clear_acc_data", int'(acc_data), 0);
        chk("clear_term_count", int'(term_count), 0);
        chk("clear_overflow", int'(overflow), 0);
        chk("clear_prod_ready", int'(prod_ready), 1);
    endtask

    // reset pulse placed between clock edges
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_acc_data", int'(acc_data), 0);
        chk("rst_term_count", int'(term_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_acc_valid", int'(acc_valid), 0);
        chk("rst_prod_ready", int'(prod_ready), 0);
        exp_q.delete();
        m_cnt = 0; m_acc = 0; m_ovf = 1'b0;
        #4 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_held", int'(prod_ready), 0);
        @(negedge clk);
        chk("rst_ready_rise", int'(prod_ready), 1);
    endtask

    always @(negedge clk) if (rand_rdy) acc_ready = ($urandom_range(0, 3) != 0);

    // monitor: pops the scoreboard on each result handshake
    bit   hold_prev = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && acc_valid) begin
            chk("hold_prod_ready", int'(prod_ready), 0);
            if (acc_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_acc_data", int'(acc_data), e.acc);
                    chk("res_overflow", int'(overflow), int'(e.ovf));
                    chk("res_term_count", int'(term_count), e.cnt);
                end
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("stable_acc_data", int'(acc_data), held.acc);
                    chk("stable_overflow", int'(overflow), int'(held.ovf));
                    chk("stable_term_count", int'(term_count), held.cnt);
                end
                held.acc = int'(acc_data);
                held.ovf = overflow;
                held.cnt = int'(term_count);
                hold_prev = 1'b1;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        logic signed [7:0] b;
        int p;

        // reset state while held, then release between edges
        #2;
        chk("init_prod_ready", int'(prod_ready), 0);
        chk("init_acc_valid", int'(acc_valid), 0);
        chk("init_acc_data", int'(acc_data), 0);
        chk("init_term_count", int'(term_count), 0);
        #20 rst_n = 1'b1;
        #1 chk("init_ready_before_clk", int'(prod_ready), 0);
        @(negedge clk);
        chk("init_ready_after_clk", int'(prod_ready), 1);

        // single-term sums: each accept produces a result
        chk("one_ready", int'(c_ready), 1);
        c_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? -8'sd7 : 8'($urandom);
            c_data = b;
            @(negedge clk);
            chk("one_valid", int'(c_acc_valid), 1);
            chk("one_data", int'(c_acc), int'(b));
            if (i == 0) chk("one_data_hex", int'($unsigned(c_acc)), 16'hFFF9);
            chk("one_cnt", int'(c_cnt), 1);
            chk("one_ready_hold", int'(c_ready), 0);
            @(negedge clk);
            chk("one_idle_valid", int'(c_acc_valid), 0);
            chk("one_idle_data", int'(c_acc), 0);
        end
        c_valid = 1'b0;

        // basic back-to-back sum
        acc_ready = 1'b1;
        send(15, 0); send(-14, 0); send(49, 0); send(64, 0);
        @(negedge clk);

        // gaps between products and backpressure in HOLD
        acc_ready = 1'b0;
        send(-20, 2); send(33, 2); send(7, 2); send(-100, 0);
        fork
            send(11, 0);
            begin repeat (5) @(negedge clk); acc_ready = 1'b1; end
        join
        send(22, 0); send(-33, 0); send(44, 1);

        // overflow, then a clean sum starts with overflow clear
        send(64, 0); send(64, 0); send(0, 0); send(0, 0);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        send(-128, 0); send(-128, 0); send(127, 0); send(-1, 1);

        // clear mid-sum with a product presented alongside it
        send(10, 0); send(20, 0);
        do_clear(5);
        send(1, 0); send(1, 0); send(1, 0); send(1, 1);

        // asynchronous reset mid-accumulation
        send(3, 0); send(4, 0);
        do_reset();
        send(5, 0); send(6, 0); send(7, 0); send(8, 1);

        // asynchronous reset while holding a result
        acc_ready = 1'b0;
        send(9, 0); send(9, 0); send(9, 0); send(9, 0);
        repeat (2) @(negedge clk);
        do_reset();
        acc_ready = 1'b1;

        // randomized traffic with random backpressure and occasional clears
        rand_rdy = 1'b1;
        for (int i = 0; i < 120; i++) begin
            b = 8'($urandom);
            p = int'(b);
            if (m_cnt > 0 && $urandom_range(0, 14) == 0) do_clear(p);
            send(p, $urandom_range(0, 2));
        end
        rand_rdy = 1'b0;
        @(negedge clk);
        acc_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
- Sits directly downstream of the 4x4 signed Booth multiplier.
- Consumes its signed 8-bit products over a valid/ready stream and sums a fixed number of them (a dot-product term count) into a wider signed accumulator.
- Presents the finished sum on an output valid/ready handshake.
- Turns the combinational multiplier into a usable multiply-accumulate datapath.

Parameters:
- PROD_W, 8, signed product width; matches the multiplier output.
- ACC_W, 16, signed accumulator and result width; must be >= PROD_W.
- NUM_TERMS, 4, products summed per result; must be >= 1.
- CNT_W, 3, term counter width; must satisfy 2^CNT_W > NUM_TERMS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; discards partial sum, returns to IDLE
- prod_valid  in  1  product on prod_data is valid
- prod_ready  out  1  block can accept a product this cycle
- prod_data  in  PROD_W  signed product from the multiplier
- acc_valid  out  1  acc_data holds a completed sum
- acc_ready  in  1  downstream accepts acc_data
- acc_data  out  ACC_W  signed accumulated result
- overflow  out  1  sticky: signed overflow occurred in the current sum
- term_count  out  CNT_W  products accepted in the current sum

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc_data=0, term_count=0, overflow=0, acc_valid=0, prod_ready=0 while held.
  - prod_ready rises the first clock after release.
- Accept event: prod_valid & prod_ready at a rising edge. Product is sign-extended to ACC_W before adding.
- IDLE:
  - prod_ready=1, acc_valid=0.
  - On accept: acc_data=sext(prod_data), term_count=1, overflow=0.
  - Next state is HOLD if NUM_TERMS==1, else ACCUM.
- ACCUM:
  - prod_ready=1.
  - On accept: acc_data=acc_data+sext(prod_data), term_count+1.
  - When the accepted term is the NUM_TERMS-th, go to HOLD.
  - prod_valid low: no change; gaps of any length are allowed.
- HOLD:
  - prod_ready=0, acc_valid=1; acc_data, overflow and term_count are stable.
  - When acc_ready=1 at the edge: go to IDLE; clear acc_data, term_count and overflow on that edge.
  - prod_valid during HOLD is ignored; upstream must hold its product.
- Latency: acc_valid rises on the edge that accepts the NUM_TERMS-th product, so it is visible the cycle after that accept. Minimum throughput is NUM_TERMS+1 cycles per result.
- Overflow detection: operands of equal sign whose raw sum has a different sign bit. The overflow flag sets and stays set until the result is handed off, cleared, or reset.
- clear:
  - Has priority over every state transition and accept.
  - Next state is IDLE; acc_data, term_count and overflow go to 0; acc_valid drops.
  - A product presented in the same cycle is not accepted (prod_ready still reads 1, but is qualified internally by ~clear).
- Reset mid-operation discards all state immediately; no partial result is emitted.
- Outputs are registered. prod_ready and acc_valid decode directly from state; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on overflow, acc_data clamps to the most positive value (2^(ACC_W-1)-1) or the most negative value (-2^(ACC_W-1)). The overflow flag is set. Later terms add to the clamped value and clamp again if needed.
- Undefined: the sum wraps modulo 2^ACC_W. The overflow flag is still set.

Test Plan:
- Basic sum, defaults: feed 15, -14, 49, 64 (from 3*5, -2*7, 7*7, -8*-8) back-to-back with acc_ready=1. Expect acc_valid one cycle after the 4th accept, acc_data=114, overflow=0, term_count=4, then IDLE.
- Stream gaps and backpressure: insert 2 idle cycles between products and hold acc_ready=0 for 5 cycles in HOLD. Expect acc_data stable, prod_ready=0 throughout HOLD, and a new product presented in HOLD not consumed until after the handoff.
- Overflow with ACC_W=8, NUM_TERMS=4: feed 64, 64, 0, 0.
  - Without the macro: expect acc_data=-128 (0x80) and overflow=1.
  - With ACC_SATURATE_EN: expect acc_data=127 and overflow=1.
  - The next sum starts with overflow=0.
- Clear mid-sum: accept 10 and 20, then assert clear with prod_valid=1 carrying 5. Expect IDLE, acc_data=0, term_count=0, and the 5 not counted. A following sum of 1, 1, 1, 1 gives 4.
- Async reset mid-ACCUM and in HOLD: pulse rst_n low between edges. Expect all outputs 0 immediately with no acc_valid pulse; normal operation resumes on the first clock after release.
- NUM_TERMS=1: each accepted product goes directly to HOLD. Feed -7: expect acc_data=-7 (sign-extended 0xFFF9), one result per accept.
